// File: rtl/cail_param_arb_pkg.sv
// Shared encodings and widths for the calibration-parameter EEPROM arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package cail_param_arb_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int SAVE_CNT_W = 20;

    typedef enum logic [1:0] {
        CMD_RD   = 2'b00,
        CMD_WR   = 2'b01,
        CMD_SAVE = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_t;

    typedef enum logic [6:0] {
        ST_WAIT_INIT = 7'b000_0001,
        ST_IDLE      = 7'b000_0010,
        ST_RD        = 7'b000_0100,
        ST_WR        = 7'b000_1000,
        ST_GAP       = 7'b001_0000,
        ST_SAVE      = 7'b010_0000,
        ST_DONE      = 7'b100_0000
    } state_t;

    typedef struct packed {
        cmd_t              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cail_arb_rr2.sv
// Two-input round-robin grant. The pointer names the requester that wins a tie
// and moves to the other requester after every grant.
module cail_arb_rr2
    import cail_param_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (&req) gnt = ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr <= 1'b0;
        else if (|gnt)  ptr <= gnt[0];
    end

endmodule

// File: rtl/cail_param_arb.sv
// Arbitrates the host path and the calibration engine onto the EEPROM controller,
// turning req/done handshakes into level-held rd/wr requests and a pulsed update.
module cail_param_arb
    import cail_param_arb_pkg::*;
#(
    parameter int RD_LAT      = 5,
    parameter int WR_HOLD     = 3,
    parameter int GAP         = 2,
    parameter int SAVE_CYCLES = 300000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic [1:0]        r0_cmd,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic [1:0]        r1_cmd,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ready,
    input  logic              ctl_init_done,
    output logic              ctl_wr_req,
    output logic              ctl_rd_req,
    output logic              ctl_update_req,
    output logic [ADDR_W-1:0] ctl_wr_addr,
    output logic [ADDR_W-1:0] ctl_rd_addr,
    output logic [DATA_W-1:0] ctl_wr_data,
    input  logic [DATA_W-1:0] ctl_rd_data
);

    localparam int HOLD_MAX = max3(RD_LAT, WR_HOLD, GAP);
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [HOLD_W-1:0]     RD_LAST   = HOLD_W'(RD_LAT - 1);
    localparam logic [HOLD_W-1:0]     WR_LAST   = HOLD_W'(WR_HOLD - 1);
    localparam logic [HOLD_W-1:0]     GAP_LAST  = HOLD_W'(GAP - 1);
    localparam logic [SAVE_CNT_W-1:0] SAVE_LAST = SAVE_CNT_W'(SAVE_CYCLES - 1);

    state_t                state;
    logic                  sel;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [SAVE_CNT_W-1:0] save_cnt;

    logic [1:0] req_v;
    logic [1:0] gnt;
    logic       sel_g;
    req_t       rq0, rq1, g;

    // Requests only compete while idle; anything raised elsewhere stays pending.
    assign req_v = (state == ST_IDLE) ? {r1_req, r0_req} : 2'b00;

    cail_arb_rr2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_v),
        .gnt   (gnt)
    );

    always_comb begin
        rq0.cmd   = cmd_t'(r0_cmd);
        rq0.addr  = r0_addr;
        rq0.wdata = r0_wdata;
        rq1.cmd   = cmd_t'(r1_cmd);
        rq1.addr  = r1_addr;
        rq1.wdata = r1_wdata;
    end

    assign sel_g = gnt[1];
    assign g     = sel_g ? rq1 : rq0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_WAIT_INIT;
            sel            <= 1'b0;
            hold_cnt       <= '0;
            save_cnt       <= '0;
            ready          <= 1'b0;
            r0_done        <= 1'b0;
            r1_done        <= 1'b0;
            r0_rdata       <= '0;
            r1_rdata       <= '0;
            ctl_wr_req     <= 1'b0;
            ctl_rd_req     <= 1'b0;
            ctl_update_req <= 1'b0;
            ctl_wr_addr    <= '0;
            ctl_rd_addr    <= '0;
            ctl_wr_data    <= '0;
        end else begin
            r0_done        <= 1'b0;
            r1_done        <= 1'b0;
            ctl_update_req <= 1'b0;

            case (state)
                ST_WAIT_INIT: begin
                    if (ctl_init_done) begin
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (|gnt) begin
                        sel      <= sel_g;
                        hold_cnt <= '0;
                        save_cnt <= '0;
                        case (g.cmd)
                            CMD_RD: begin
                                ctl_rd_addr <= g.addr;
                                ctl_rd_req  <= 1'b1;
                                state       <= ST_RD;
                            end
                            CMD_WR: begin
                                ctl_wr_addr <= g.addr;
                                ctl_wr_data <= g.wdata;
                                ctl_wr_req  <= 1'b1;
                                state       <= ST_WR;
                            end
                            CMD_SAVE: begin
                                ctl_update_req <= 1'b1;
                                state          <= ST_SAVE;
                            end
                            default: begin
                                // Reserved command completes at once with zero data.
                                if (sel_g) begin
                                    r1_rdata <= '0;
                                    r1_done  <= 1'b1;
                                end else begin
                                    r0_rdata <= '0;
                                    r0_done  <= 1'b1;
                                end
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end

                ST_RD: begin
                    if (hold_cnt == RD_LAST) begin
                        if (sel) r1_rdata <= ctl_rd_data;
                        else     r0_rdata <= ctl_rd_data;
                        ctl_rd_req <= 1'b0;
                        hold_cnt   <= '0;
                        state      <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_WR: begin
                    if (hold_cnt == WR_LAST) begin
                        ctl_wr_req <= 1'b0;
                        hold_cnt   <= '0;
                        state      <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (hold_cnt == GAP_LAST) begin
                        if (sel) r1_done <= 1'b1;
                        else     r0_done <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_SAVE: begin
                    // The update pulse occupies the first of these cycles.
                    if (save_cnt == SAVE_LAST) begin
                        if (sel) r1_done <= 1'b1;
                        else     r0_done <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        save_cnt <= save_cnt + 1'b1;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cail_param_arb.sv
// Directed bench for cail_param_arb: init gating, read/write/save/reserved
// transactions, round-robin ordering and reset mid-read.
module tb_cail_param_arb;

    localparam int RD_LAT = 5;

    logic       clk, rst_n;
    logic       r0_req, r1_req;
    logic [1:0] r0_cmd, r1_cmd;
    logic [9:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_done, r1_done;
    logic [7:0] r0_rdata, r1_rdata;
    logic       ready, ctl_init_done;
    logic       ctl_wr_req, ctl_rd_req, ctl_update_req;
    logic [9:0] ctl_wr_addr, ctl_rd_addr;
    logic [7:0] ctl_wr_data, ctl_rd_data;

    int n_vec, n_err, viol;

    cail_param_arb #(.SAVE_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_rdata(r1_rdata),
        .ready(ready), .ctl_init_done(ctl_init_done),
        .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_update_req(ctl_update_req),
        .ctl_wr_addr(ctl_wr_addr), .ctl_rd_addr(ctl_rd_addr), .ctl_wr_data(ctl_wr_data),
        .ctl_rd_data(ctl_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: the byte is only valid on the RD_LAT-th cycle of rd_req.
    logic [3:0] rd_cnt = '0;
    always @(posedge clk) rd_cnt <= ctl_rd_req ? rd_cnt + 4'd1 : 4'd0;
    always_comb begin
        ctl_rd_data = 8'hEE;
        if (ctl_rd_req && rd_cnt == 4'(RD_LAT - 1)) ctl_rd_data = ctl_rd_addr[7:0] ^ 8'h0A;
    end

    // Exclusivity, single-done and hold-stability monitor.
    logic       p_wr, p_rd;
    logic [9:0] p_wa, p_ra;
    logic [7:0] p_wd;
    initial viol = 0;
    always @(negedge clk) begin
        if (int'(ctl_rd_req) + int'(ctl_wr_req) + int'(ctl_update_req) > 1) viol++;
        if (r0_done && r1_done) viol++;
        if (ctl_wr_req && p_wr && (ctl_wr_addr != p_wa || ctl_wr_data != p_wd)) viol++;
        if (ctl_rd_req && p_rd && ctl_rd_addr != p_ra) viol++;
        p_wr = ctl_wr_req; p_rd = ctl_rd_req;
        p_wa = ctl_wr_addr; p_wd = ctl_wr_data; p_ra = ctl_rd_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on the negedge of the grant cycle (cycle 1); returns at done or after maxc.
    task automatic watch(input int which, input int maxc, input bit scr,
                         output int lat, output int rd_n, output int wr_n, output int up_n,
                         output int first, output int odone,
                         output logic [9:0] ra, output logic [9:0] wa, output logic [7:0] wd);
        lat = 0; rd_n = 0; wr_n = 0; up_n = 0; first = 0; odone = 0;
        ra = '0; wa = '0; wd = '0;
        for (int c = 2; c <= maxc; c++) begin
            @(negedge clk);
            if (scr && c == 3) begin
                if (which == 1) begin r1_addr = '0; r1_wdata = '0; r1_cmd = 2'b11; end
                else            begin r0_addr = '0; r0_wdata = '0; r0_cmd = 2'b11; end
            end
            rd_n += int'(ctl_rd_req); wr_n += int'(ctl_wr_req); up_n += int'(ctl_update_req);
            if (ctl_rd_req) ra = ctl_rd_addr;
            if (ctl_wr_req) begin wa = ctl_wr_addr; wd = ctl_wr_data; end
            if (first == 0 && (ctl_rd_req || ctl_wr_req || ctl_update_req)) first = c;
            if (which == 0 ? r1_done : r0_done) odone++;
            if (which == 0 ? r0_done : r1_done) begin lat = c; break; end
        end
    endtask

    int lat, rd_n, wr_n, up_n, first, odone, cnt;
    logic [9:0] ra, wa;
    logic [7:0] wd;

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; ctl_init_done = 1'b0;
        r0_req = 0; r0_cmd = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_cmd = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_ctl_reqs", {ctl_rd_req, ctl_wr_req, ctl_update_req}, 0);
        chk("rst_done", {r0_done, r1_done}, 0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
        chk("rst_ctl_bus", {ctl_wr_addr, ctl_rd_addr, ctl_wr_data}, 0);
        rst_n = 1'b1;

        // 1: init gating then first read
        @(negedge clk);
        r0_req = 1; r0_cmd = 2'b00; r0_addr = 10'd5;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(ctl_rd_req | ctl_wr_req | ctl_update_req);
        end
        chk("t1_pre_ctl", cnt, 0);
        chk("t1_pre_ready", ready, 0);
        ctl_init_done = 1;
        @(negedge clk);
        ctl_init_done = 0;
        chk("t1_ready", ready, 1);
        chk("t1_idle_rd", ctl_rd_req, 0);
        watch(0, 20, 1'b1, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t1_lat", lat, 9);
        chk("t1_rd_hold", rd_n, 5);
        chk("t1_first", first, 2);
        chk("t1_rd_addr", ra, 10'd5);
        chk("t1_rdata", r0_rdata, 8'h0F);
        chk("t1_other_done", odone, 0);
        r0_req = 0;
        @(negedge clk);

        // 2: write on r1, inputs scrambled after grant
        r1_req = 1; r1_cmd = 2'b01; r1_addr = 10'h3FF; r1_wdata = 8'hA5;
        watch(1, 20, 1'b1, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t2_lat", lat, 7);
        chk("t2_wr_hold", wr_n, 3);
        chk("t2_no_rd", rd_n + up_n, 0);
        chk("t2_wr_addr", wa, 10'h3FF);
        chk("t2_wr_data", wd, 8'hA5);
        chk("t2_r0_done", odone, 0);
        r1_req = 0;

        // 3: simultaneous reads after reset, then a repeated pair
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        ctl_init_done = 1;
        @(negedge clk);
        ctl_init_done = 0;
        r0_req = 1; r0_cmd = 2'b00; r0_addr = 10'd1;
        r1_req = 1; r1_cmd = 2'b00; r1_addr = 10'd2;
        watch(0, 20, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t3a_lat_r0", lat, 9);
        chk("t3a_rdata", r0_rdata, 8'h0B);
        chk("t3a_r1_done", odone, 0);
        @(negedge clk);
        r0_addr = 10'd3;
        watch(1, 20, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t3b_lat_r1", lat, 9);
        chk("t3b_rdata", r1_rdata, 8'h08);
        chk("t3b_r0_done", odone, 0);
        r1_req = 0;
        @(negedge clk);
        watch(0, 20, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t3c_lat_r0", lat, 9);
        chk("t3c_rdata", r0_rdata, 8'h09);
        r0_req = 0;
        @(negedge clk);

        // 4: save blocks a pending write for the whole save period
        r0_req = 1; r0_cmd = 2'b10;
        fork
            begin
                @(negedge clk);
                r1_req = 1; r1_cmd = 2'b01; r1_addr = 10'h02A; r1_wdata = 8'h5C;
            end
        join_none
        watch(0, 70, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t4_lat", lat, 52);
        chk("t4_update_n", up_n, 1);
        chk("t4_update_first", first, 2);
        chk("t4_no_rdwr", rd_n + wr_n, 0);
        chk("t4_r1_done", odone, 0);
        r0_req = 0;
        @(negedge clk);
        watch(1, 20, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t4_wr_lat", lat, 7);
        chk("t4_wr_hold", wr_n, 3);
        chk("t4_wr_bus", {wa, wd}, {10'h02A, 8'h5C});
        r1_req = 0;
        @(negedge clk);

        // 5: reserved command
        r1_req = 1; r1_cmd = 2'b11;
        watch(1, 10, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t5_lat", lat, 2);
        chk("t5_no_ctl", rd_n + wr_n + up_n, 0);
        chk("t5_rdata", r1_rdata, 8'h00);
        r1_req = 0;
        @(negedge clk);

        // 6: reset during the read hold
        r0_req = 1; r0_cmd = 2'b00; r0_addr = 10'd7;
        repeat (3) @(negedge clk);
        chk("t6_rd_active", ctl_rd_req, 1);
        rst_n = 0;
        #1;
        chk("t6_rd_dropped", ctl_rd_req, 0);
        chk("t6_ready_low", ready, 0);
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(r0_done | r1_done | ctl_rd_req | ctl_wr_req | ctl_update_req);
        end
        chk("t6_quiet", cnt, 0);
        chk("t6_ready_wait", ready, 0);
        ctl_init_done = 1;
        @(negedge clk);
        ctl_init_done = 0;
        chk("t6_ready", ready, 1);
        watch(0, 20, 1'b0, lat, rd_n, wr_n, up_n, first, odone, ra, wa, wd);
        chk("t6_lat", lat, 9);
        chk("t6_rdata", r0_rdata, 8'h0D);
        r0_req = 0;
        repeat (2) @(negedge clk);

        chk("monitor_viol", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
